// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Brief    : Dual-read, dual-write register file with forwarding and a
//            sequential zero-fill (wipe) engine.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [AW-1:0]    Aaddr,
    input  logic [AW-1:0]    Baddr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             load,
    input  logic [AW-1:0]    Caddr,
    input  logic [WIDTH-1:0] C,
    input  logic             loadD,
    input  logic [AW-1:0]    Daddr,
    input  logic [WIDTH-1:0] D,
    input  logic             wipe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WIPE = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_next;
    logic             w_done_next;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_wiping;
    logic w_zero_c;
    logic w_zero_d;
    logic w_we_c;
    logic w_we_d;

    assign w_wiping = (r_state == S_WIPE);
    assign w_zero_c = (ZERO_R0 != 0) && (Caddr == '0);
    assign w_zero_d = (ZERO_R0 != 0) && (Daddr == '0);
    assign w_we_c   = load && !w_wiping && !w_zero_c;
    // Port C owns a shared address, so port D backs off whenever C targets it.
    assign w_we_d   = loadD && !w_wiping && !w_zero_d && !(load && (Daddr == Caddr));

    // Value a register will hold after the current edge.
    function automatic logic [WIDTH-1:0] f_fwd(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] v;
        v = r_mem[addr];
        if (w_we_d && (addr == Daddr)) v = D;
        if (w_we_c && (addr == Caddr)) v = C;
        if (w_wiping && (addr == r_cnt)) v = '0;
        if ((ZERO_R0 != 0) && (addr == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        busy         = (r_state == S_WIPE);
        case (r_state)
            S_IDLE: begin
                if (wipe) begin
                    w_state_next = S_WIPE;
                    w_cnt_next   = '0;
                end
            end
            S_WIPE: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            done    <= 1'b0;
            A       <= '0;
            B       <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            done    <= w_done_next;
            A       <= f_fwd(Aaddr);
            B       <= f_fwd(Baddr);
            if (w_wiping) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_we_c) r_mem[Caddr] <= C;
                if (w_we_d) r_mem[Daddr] <= D;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_param
// Brief    : Directed self-checking bench for reg_file_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [3:0]  Aaddr = '0, Baddr = '0, Caddr = '0, Daddr = '0;
    logic [15:0] C = '0, D = '0;
    logic        load = 1'b0, loadD = 1'b0, wipe = 1'b0;
    logic [15:0] A, B, zA, zB;
    logic        busy, done, zbusy, zdone;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_R0(0)) dut (
        .clk(clk), .clear(clear), .Aaddr(Aaddr), .Baddr(Baddr), .A(A), .B(B),
        .load(load), .Caddr(Caddr), .C(C), .loadD(loadD), .Daddr(Daddr), .D(D),
        .wipe(wipe), .busy(busy), .done(done)
    );

    reg_file_param #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_R0(1)) dut_z (
        .clk(clk), .clear(clear), .Aaddr(Aaddr), .Baddr(Baddr), .A(zA), .B(zB),
        .load(load), .Caddr(Caddr), .C(C), .loadD(loadD), .Daddr(Daddr), .D(D),
        .wipe(wipe), .busy(zbusy), .done(zdone)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] val);
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; Caddr = 4'(2*i);     C = val;
            loadD = 1'b1; Daddr = 4'(2*i + 1); D = val;
            tick();
        end
        load = 1'b0; loadD = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; Aaddr = 4'd3; Baddr = 4'd15;
        tick();
        clear = 1'b0;
        n_cmp++; if (A !== 16'h0000) begin n_err++; $display("FAIL reset_A: got %h want 0000", A); end
        n_cmp++; if (B !== 16'h0000) begin n_err++; $display("FAIL reset_B: got %h want 0000", B); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (zA !== 16'h0000) begin n_err++; $display("FAIL reset_zA: got %h want 0000", zA); end
    endtask

    task automatic test_forward();
        load = 1'b1; Caddr = 4'd5; C = 16'hBEEF; Aaddr = 4'd5; Baddr = 4'd5;
        tick();
        load = 1'b0;
        n_cmp++; if (A !== 16'hBEEF) begin n_err++; $display("FAIL fwd_A: got %h want beef", A); end
        n_cmp++; if (B !== 16'hBEEF) begin n_err++; $display("FAIL fwd_B: got %h want beef", B); end
        Aaddr = 4'd6;
        tick();
        n_cmp++; if (B !== 16'hBEEF) begin n_err++; $display("FAIL stored_B: got %h want beef", B); end
        n_cmp++; if (A !== 16'h0000) begin n_err++; $display("FAIL untouched_A: got %h want 0000", A); end
    endtask

    task automatic test_dual_write();
        load = 1'b1; Caddr = 4'd7; C = 16'h1111;
        loadD = 1'b1; Daddr = 4'd7; D = 16'h2222; Aaddr = 4'd7;
        tick();
        n_cmp++; if (A !== 16'h1111) begin n_err++; $display("FAIL clash_fwd: got %h want 1111", A); end
        Caddr = 4'd9; C = 16'h4444; Daddr = 4'd8; D = 16'h3333; Aaddr = 4'd8; Baddr = 4'd9;
        tick();
        n_cmp++; if (A !== 16'h3333) begin n_err++; $display("FAIL dual_fwd_D: got %h want 3333", A); end
        n_cmp++; if (B !== 16'h4444) begin n_err++; $display("FAIL dual_fwd_C: got %h want 4444", B); end
        load = 1'b0; loadD = 1'b0; Aaddr = 4'd7; Baddr = 4'd8;
        tick();
        n_cmp++; if (A !== 16'h1111) begin n_err++; $display("FAIL clash_stored: got %h want 1111", A); end
        n_cmp++; if (B !== 16'h3333) begin n_err++; $display("FAIL dual_stored_D: got %h want 3333", B); end
        Aaddr = 4'd9;
        tick();
        n_cmp++; if (A !== 16'h4444) begin n_err++; $display("FAIL dual_stored_C: got %h want 4444", A); end
    endtask

    task automatic test_zero_r0();
        load = 1'b1; Caddr = 4'd0; C = 16'hFFFF; Aaddr = 4'd0; Baddr = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (zA !== 16'h0000) begin n_err++; $display("FAIL zr0_A[%0d]: got %h want 0000", k, zA); end
            n_cmp++; if (A !== 16'hFFFF) begin n_err++; $display("FAIL r0_plain[%0d]: got %h want ffff", k, A); end
        end
        Caddr = 4'd1; C = 16'h0101; Baddr = 4'd1;
        tick();
        load = 1'b0;
        n_cmp++; if (zB !== 16'h0101) begin n_err++; $display("FAIL zr0_r1: got %h want 0101", zB); end
        tick();
        n_cmp++; if (zA !== 16'h0000) begin n_err++; $display("FAIL zr0_read: got %h want 0000", zA); end
    endtask

    task automatic test_wipe();
        logic [15:0] ea, eb;
        fill(16'hA5A5);
        Aaddr = 4'd15; Baddr = 4'd3;
        tick();
        n_cmp++; if (A !== 16'hA5A5) begin n_err++; $display("FAIL fill_A: got %h want a5a5", A); end
        wipe = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wipe_start_busy: got %b want 1", busy); end
        load = 1'b1; Caddr = 4'd3; C = 16'h1234;
        loadD = 1'b1; Daddr = 4'd4; D = 16'h5678;
        for (int k = 1; k <= 16; k++) begin
            wipe = (k <= 3);
            tick();
            ea = (k == 16) ? 16'h0000 : 16'hA5A5;
            eb = (k >= 4) ? 16'h0000 : 16'hA5A5;
            n_cmp++; if (busy !== (k < 16)) begin n_err++; $display("FAIL wipe_busy[%0d]: got %b want %b", k, busy, (k < 16)); end
            n_cmp++; if (done !== (k == 16)) begin n_err++; $display("FAIL wipe_done[%0d]: got %b want %b", k, done, (k == 16)); end
            n_cmp++; if (A !== ea) begin n_err++; $display("FAIL wipe_A[%0d]: got %h want %h", k, A, ea); end
            n_cmp++; if (B !== eb) begin n_err++; $display("FAIL wipe_B[%0d]: got %h want %h", k, B, eb); end
        end
        load = 1'b0; loadD = 1'b0; wipe = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL wipe_done_end: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wipe_busy_end: got %b want 0", busy); end
        for (int i = 0; i < 16; i++) begin
            Aaddr = 4'(i); Baddr = 4'(15 - i);
            tick();
            n_cmp++; if (A !== 16'h0000) begin n_err++; $display("FAIL wiped_A[%0d]: got %h want 0000", i, A); end
            n_cmp++; if (B !== 16'h0000) begin n_err++; $display("FAIL wiped_B[%0d]: got %h want 0000", 15 - i, B); end
        end
    endtask

    task automatic test_clear_mid_wipe();
        logic [15:0] ea;
        fill(16'hA5A5);
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        clear = 1'b1; load = 1'b1; Caddr = 4'd10; C = 16'hDEAD;
        tick();
        clear = 1'b0; load = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
        load = 1'b1; Caddr = 4'd2; C = 16'h0F0F; Aaddr = 4'd2;
        tick();
        load = 1'b0;
        n_cmp++; if (A !== 16'h0F0F) begin n_err++; $display("FAIL post_clear_write: got %h want 0f0f", A); end
        for (int i = 0; i < 16; i++) begin
            Aaddr = 4'(i);
            tick();
            ea = (i == 2) ? 16'h0F0F : 16'h0000;
            n_cmp++; if (A !== ea) begin n_err++; $display("FAIL cleared_A[%0d]: got %h want %h", i, A, ea); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_nodone[%0d]: got %b want 0", i, done); end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_dual_write();
        test_zero_r0();
        test_wipe();
        test_clear_mid_wipe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
